// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice with a registered carry.
// Results (sum, carry/borrow, signed overflow, zero) are published only when DONE is entered.

module serial_adder_sub_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_s,
    output logic             o_c
);
    logic [DIGIT:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_c};
    assign o_s    = w_full[DIGIT-1:0];
    assign o_c    = w_full[DIGIT];
endmodule

module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // FIN is the settle cycle between the last digit and publishing the result.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [WIDTH-1:0] w_res_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_amsb, r_bmsb;
    logic             w_accept, w_last;
    logic [DIGIT-1:0] w_s;
    logic             w_c;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

    serial_adder_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .i_a (r_a[DIGIT-1:0]),
        .i_b (r_b[DIGIT-1:0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    // New digit enters the result register from the MSB end.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_res_next = w_s;
        end else begin : g_part
            assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c;
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
        end else if (r_state == S_FIN) begin
            sum     <= r_res;
            cout    <= r_carry;
            ovf     <= (r_amsb == r_bmsb) && (r_res[WIDTH-1] != r_amsb);
            zero    <= (r_res == '0);
        end
    end
endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub: main checks at WIDTH=8/DIGIT=1,
// latency checks on DIGIT=4 and DIGIT=8 instances sharing the same stimulus.

module tb_serial_adder_sub;
    logic       clk = 1'b0;
    logic       rst, start, sub, cin;
    logic [7:0] a, b;

    logic       busy1, done1, cout1, ovf1, zero1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4, ovf4, zero4;
    logic [7:0] sum4;
    logic       busy8, done8, cout8, ovf8, zero8;
    logic [7:0] sum8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } res_t;

    res_t sb[$];

    serial_adder_sub #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));
    serial_adder_sub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4));
    serial_adder_sub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));

    always #5 clk = ~clk;

    // Reference: unsigned sum/borrow plus overflow from true signed range.
    function automatic res_t model(input logic [7:0] ai, input logic [7:0] bi,
                                   input logic ci, input logic si);
        res_t r;
        int   sa, sbv, full;
        sa  = $signed(ai);
        sbv = $signed(bi);
        if (si) begin
            r.sum  = ai - bi;
            r.cout = (ai >= bi);
            full   = sa - sbv;
        end else begin
            {r.cout, r.sum} = {1'b0, ai} + {1'b0, bi} + {8'b0, ci};
            full = sa + sbv + (ci ? 1 : 0);
        end
        r.ovf  = (full > 127) || (full < -128);
        r.zero = (r.sum == 8'h00);
        return r;
    endfunction

    function automatic res_t obs1();
        return {sum1, cout1, ovf1, zero1};
    endfunction

    // Call at a negedge; returns at the negedge after the accept edge.
    task automatic issue_op(input logic [7:0] ai, input logic [7:0] bi,
                            input logic ci, input logic si, input res_t exp);
        a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done(output int edges, output int busy_cyc);
        edges = 0; busy_cyc = 0;
        while (done1 !== 1'b1 && edges < 40) begin
            if (busy1 === 1'b1) busy_cyc++;
            @(posedge clk); edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy1, done1, sum1, cout1, ovf1, zero1} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy1, done1, sum1, cout1, ovf1, zero1);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy1, done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy1, done1);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta[8] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h80, 8'h00, 8'h3C, 8'h10};
        logic [7:0] tb_[8] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h80, 8'h00, 8'h0F, 8'h01};
        logic       tc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       ts[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        res_t       te[8] = '{{8'h00, 1'b1, 1'b0, 1'b1}, {8'h81, 1'b0, 1'b1, 1'b0},
                              {8'hFE, 1'b0, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1, 1'b0},
                              {8'h00, 1'b1, 1'b1, 1'b1}, {8'h00, 1'b1, 1'b0, 1'b1},
                              {8'h4C, 1'b0, 1'b0, 1'b0}, {8'h0F, 1'b1, 1'b0, 1'b0}};
        int   edges, bc;
        res_t exp, got;
        for (int i = 0; i < 8; i++) begin
            issue_op(ta[i], tb_[i], tc[i], ts[i], te[i]);
            wait_done(edges, bc);
            exp = sb.pop_front();
            got = obs1();
            n_tests++;
            if (edges != 9) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d edges, want 9", i, edges);
            end
            n_tests++;
            if (bc != 8) begin
                n_fail++;
                $display("FAIL dir%0d_busy: got %0d busy cycles, want 8", i, bc);
            end
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dir%0d_result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                         i, got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
            end
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_done_width: done=%b one cycle later, want 0", i, done1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int   edges, bc;
        res_t exp, got;
        issue_op(8'h11, 8'h22, 1'b0, 1'b0, '{8'h33, 1'b0, 1'b0, 1'b0});
        repeat (2) begin @(posedge clk); @(negedge clk); end
        a = 8'hF0; b = 8'hF0; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, bc);
        exp = sb.pop_front();
        got = obs1();
        n_tests++;
        if (edges + 3 != 9) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d edges, want 9", edges + 3);
        end
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ignore_result: got sum=%h c=%b v=%b z=%b, want sum=%h",
                     got.sum, got.cout, got.ovf, got.zero, exp.sum);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy1, done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_no_requeue: got busy=%b done=%b, want 0 0", busy1, done1);
        end
    endtask

    task automatic test_back_to_back();
        int   edges, bc, pre;
        logic stable;
        res_t exp, got;
        issue_op(8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0, 1'b0});
        wait_done(edges, bc);
        exp = sb.pop_front();
        got = obs1();
        n_tests++;
        if (got !== exp || edges != 9) begin
            n_fail++;
            $display("FAIL b2b_first: got sum=%h after %0d edges, want %h after 9", got.sum, edges, exp.sum);
        end
        issue_op(8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1, 1'b0});
        n_tests++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept_in_done: busy=%b after DONE-cycle start, want 1", busy1);
        end
        stable = 1'b1;
        pre = 0;
        repeat (4) begin
            if (sum1 !== 8'h46 || done1 !== 1'b0) stable = 1'b0;
            @(posedge clk); pre++;
            @(negedge clk);
        end
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL b2b_hold: outputs changed during RUN, sum=%h done=%b, want 46 0", sum1, done1);
        end
        wait_done(edges, bc);
        exp = sb.pop_front();
        got = obs1();
        n_tests++;
        if (pre + edges != 9) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d edges, want 9", pre + edges);
        end
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                     got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int   edges, bc, seen;
        res_t exp, got;
        issue_op(8'h55, 8'h22, 1'b0, 1'b0, '{8'h77, 1'b0, 1'b0, 1'b0});
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_tests++;
        if ({busy1, done1, sum1, cout1, ovf1, zero1} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_async_clear: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
                     busy1, done1, sum1, cout1, ovf1, zero1);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_abort: got %0d busy/done cycles after abort, want 0", seen);
        end
        issue_op(8'hC8, 8'h37, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1});
        wait_done(edges, bc);
        exp = sb.pop_front();
        got = obs1();
        n_tests++;
        if (got !== exp || edges != 9) begin
            n_fail++;
            $display("FAIL rst_recover: got sum=%h c=%b v=%b z=%b after %0d edges, want sum=%h c=%b v=%b z=%b after 9",
                     got.sum, got.cout, got.ovf, got.zero, edges, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int         edges, bc;
        logic [7:0] ra, rb;
        logic       rc, rs;
        res_t       exp, got;
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            issue_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
            wait_done(edges, bc);
            exp = sb.pop_front();
            got = obs1();
            n_tests++;
            if (got !== exp || edges != 9) begin
                n_fail++;
                $display("FAIL rand%0d %h %s %h cin=%b: got sum=%h c=%b v=%b z=%b edges=%0d, want sum=%h c=%b v=%b z=%b edges=9",
                         i, ra, rs ? "-" : "+", rb, rc, got.sum, got.cout, got.ovf, got.zero, edges,
                         exp.sum, exp.cout, exp.ovf, exp.zero);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_digit();
        logic [7:0] ta[2] = '{8'h3C, 8'h80};
        logic [7:0] tb_[2] = '{8'h0F, 8'h01};
        logic       ts[2] = '{1'b0, 1'b1};
        res_t       te[2] = '{{8'h4B, 1'b0, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1, 1'b0}};
        int   e4, e8;
        res_t r4, r8, exp;
        for (int i = 0; i < 2; i++) begin
            e4 = 0; e8 = 0; r4 = '0; r8 = '0;
            issue_op(ta[i], tb_[i], 1'b0, ts[i], te[i]);
            if (done8 === 1'b1) begin e8 = -1; end
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done4 === 1'b1 && e4 == 0) begin e4 = k; r4 = {sum4, cout4, ovf4, zero4}; end
                if (done8 === 1'b1 && e8 == 0) begin e8 = k; r8 = {sum8, cout8, ovf8, zero8}; end
            end
            exp = sb.pop_front();
            n_tests++;
            if (e4 != 3 || r4 !== exp) begin
                n_fail++;
                $display("FAIL digit4_case%0d: got sum=%h c=%b v=%b z=%b at edge %0d, want sum=%h c=%b v=%b z=%b at edge 3",
                         i, r4.sum, r4.cout, r4.ovf, r4.zero, e4, exp.sum, exp.cout, exp.ovf, exp.zero);
            end
            n_tests++;
            if (e8 != 2 || r8 !== exp) begin
                n_fail++;
                $display("FAIL digit8_case%0d: got sum=%h c=%b v=%b z=%b at edge %0d, want sum=%h c=%b v=%b z=%b at edge 2",
                         i, r8.sum, r8.cout, r8.ovf, r8.zero, e8, exp.sum, exp.cout, exp.ovf, exp.zero);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_digit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
